// File: rtl/transpose_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | transpose_pkg: shared types and address helper for transpose_param |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package transpose_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_TRANSPOSE = 1'b0,
    MODE_COPY      = 1'b1
  } mode_t;

  // Destination index of source element (i, j) for a rows x cols source.
  function automatic int unsigned dst_addr(input int unsigned i,
                                           input int unsigned j,
                                           input mode_t       mode,
                                           input int unsigned rows,
                                           input int unsigned cols);
    if (mode == MODE_COPY) begin
      return i * cols + j;
    end
    return j * rows + i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_delay_line.sv
`default_nettype none
// +------------------------------------------------------------------+
// | addr_delay_line: {valid, addr} shift register matching read latency |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module addr_delay_line #(
  parameter int DEPTH = 1,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] addr_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic          empty_o
);

  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    addr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        valid_q[s] <= 1'b0;
        addr_q[s]  <= '0;
      end
    end else begin
      valid_q[0] <= push_i;
      addr_q[0]  <= push_i ? addr_i : '0;
      for (int s = 1; s < DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        addr_q[s]  <= addr_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];
  assign empty_o = ~|valid_q;

endmodule
`default_nettype wire

// File: rtl/transpose_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | transpose_param: ROWS x COLS memref transpose / copy engine        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module transpose_param
  import transpose_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int RD_LAT = 1,
  localparam int AW    = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             Ai_p0_addr_en,
  output logic [AW-1:0]    Ai_p0_addr_data,
  output logic             Ai_p0_rd_en,
  input  logic [WIDTH-1:0] Ai_p0_rd_data,
  output logic             Co_p0_addr_en,
  output logic [AW-1:0]    Co_p0_addr_data,
  output logic             Co_p0_wr_en,
  output logic [WIDTH-1:0] Co_p0_wr_data
);

  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int JW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            busy_q, done_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [WIDTH-1:0] wr_data_q;

  logic            last_w;
  logic [AW-1:0]   push_addr_w;
  logic            dl_valid_w, dl_empty_w;
  logic [AW-1:0]   dl_addr_w;

  assign last_w = (i_q == IW'(ROWS - 1)) && (j_q == JW'(COLS - 1));

  // i_q/j_q always name the element whose read is on the port this cycle.
  assign push_addr_w = AW'(dst_addr(32'(i_q), 32'(j_q), mode_q, ROWS, COLS));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    i_d       = i_q;
    j_d       = j_q;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (t) begin
          state_d = ISSUE;
          mode_d  = mode_t'(mode);
          i_d     = '0;
          j_d     = '0;
          rd_en_d = 1'b1;
        end
      end
      ISSUE: begin
        if (last_w) begin
          state_d = DRAIN;
        end else begin
          if (j_q == JW'(COLS - 1)) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          rd_en_d   = 1'b1;
          rd_addr_d = AW'(32'(i_d) * 32'(COLS) + 32'(j_d));
        end
      end
      DRAIN: begin
        if (dl_empty_w) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_TRANSPOSE;
      i_q       <= '0;
      j_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      i_q       <= i_d;
      j_q       <= j_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      wr_en_q   <= dl_valid_w;
      wr_addr_q <= dl_valid_w ? dl_addr_w : '0;
      wr_data_q <= dl_valid_w ? Ai_p0_rd_data : '0;
    end
  end

  addr_delay_line #(
    .DEPTH (RD_LAT),
    .AW    (AW)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rd_en_q),
    .addr_i  (push_addr_w),
    .valid_o (dl_valid_w),
    .addr_o  (dl_addr_w),
    .empty_o (dl_empty_w)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign Ai_p0_addr_en   = rd_en_q;
  assign Ai_p0_rd_en     = rd_en_q;
  assign Ai_p0_addr_data = rd_addr_q;
  assign Co_p0_addr_en   = wr_en_q;
  assign Co_p0_wr_en     = wr_en_q;
  assign Co_p0_addr_data = wr_addr_q;
  assign Co_p0_wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_transpose_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_transpose_param: directed bench for 16x16, 4x8 (lat 3) and 1x1  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_transpose_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- DUT A: 16x16, RD_LAT=1 ----------------
  logic        tA, modeA, busyA, doneA, aenA, renA, caenA, wenA;
  logic [7:0]  raddrA, waddrA;
  logic [31:0] rdataA, wdataA;
  logic [31:0] amemA [256];
  logic [31:0] cmemA [256];
  int wcntA, rcntA, dcntA, firstA, lastA, doneAtA, protoA, kA;

  transpose_param #(.WIDTH(32), .ROWS(16), .COLS(16), .RD_LAT(1)) dutA (
    .clk(clk), .rst(rst), .t(tA), .mode(modeA), .busy(busyA), .done(doneA),
    .Ai_p0_addr_en(aenA), .Ai_p0_addr_data(raddrA), .Ai_p0_rd_en(renA),
    .Ai_p0_rd_data(rdataA), .Co_p0_addr_en(caenA), .Co_p0_addr_data(waddrA),
    .Co_p0_wr_en(wenA), .Co_p0_wr_data(wdataA));

  always @(posedge clk) rdataA <= renA ? amemA[raddrA] : 32'h0BAD0BAD;

  always @(negedge clk) begin
    if (aenA !== renA || caenA !== wenA) protoA++;
    if (renA === 1'b1) begin
      if (raddrA !== 8'(rcntA)) protoA++;
      rcntA++;
    end
    if (wenA === 1'b1) begin
      cmemA[waddrA] = wdataA;
      if (wcntA == 0) firstA = ecount;
      lastA = ecount;
      wcntA++;
    end
    if (doneA === 1'b1) begin
      dcntA++;
      doneAtA = ecount;
    end
  end

  function automatic logic anyA();
    return busyA | doneA | aenA | renA | caenA | wenA | (|raddrA) | (|waddrA) | (|wdataA);
  endfunction

  // ---------------- DUT B: 4x8, RD_LAT=3 ----------------
  logic        tB, busyB, doneB, aenB, renB, caenB, wenB;
  logic [4:0]  raddrB, waddrB;
  logic [31:0] rdataB, wdataB;
  logic [31:0] pB [3];
  logic [31:0] amemB [32];
  logic [31:0] cmemB [32];
  int wcntB, dcntB, firstB, doneAtB, kB;

  transpose_param #(.WIDTH(32), .ROWS(4), .COLS(8), .RD_LAT(3)) dutB (
    .clk(clk), .rst(rst), .t(tB), .mode(1'b0), .busy(busyB), .done(doneB),
    .Ai_p0_addr_en(aenB), .Ai_p0_addr_data(raddrB), .Ai_p0_rd_en(renB),
    .Ai_p0_rd_data(rdataB), .Co_p0_addr_en(caenB), .Co_p0_addr_data(waddrB),
    .Co_p0_wr_en(wenB), .Co_p0_wr_data(wdataB));

  always @(posedge clk) begin
    pB[0] <= renB ? amemB[raddrB] : 32'h0BAD0BAD;
    pB[1] <= pB[0];
    pB[2] <= pB[1];
  end
  assign rdataB = pB[2];

  always @(negedge clk) begin
    if (wenB === 1'b1) begin
      cmemB[waddrB] = wdataB;
      if (wcntB == 0) firstB = ecount;
      wcntB++;
    end
    if (doneB === 1'b1) begin
      dcntB++;
      doneAtB = ecount;
    end
  end

  // ---------------- DUT C: 1x1, RD_LAT=1 ----------------
  logic        tC, busyC, doneC, aenC, renC, caenC, wenC;
  logic [0:0]  raddrC, waddrC, lastRaC, lastWaC;
  logic [31:0] rdataC, wdataC, lastWdC;
  int rcntC, wcntC, dcntC, doneAtC, kC;

  transpose_param #(.WIDTH(32), .ROWS(1), .COLS(1), .RD_LAT(1)) dutC (
    .clk(clk), .rst(rst), .t(tC), .mode(1'b0), .busy(busyC), .done(doneC),
    .Ai_p0_addr_en(aenC), .Ai_p0_addr_data(raddrC), .Ai_p0_rd_en(renC),
    .Ai_p0_rd_data(rdataC), .Co_p0_addr_en(caenC), .Co_p0_addr_data(waddrC),
    .Co_p0_wr_en(wenC), .Co_p0_wr_data(wdataC));

  always @(posedge clk) rdataC <= (renC && raddrC == 1'b0) ? 32'hDEADBEEF : 32'h0BAD0BAD;

  always @(negedge clk) begin
    if (renC === 1'b1) begin
      rcntC++;
      lastRaC = raddrC;
    end
    if (wenC === 1'b1) begin
      wcntC++;
      lastWaC = waddrC;
      lastWdC = wdataC;
    end
    if (doneC === 1'b1) begin
      dcntC++;
      doneAtC = ecount;
    end
  end

  // ---------------- helpers for A ----------------
  task automatic startA(input logic m);
    @(posedge clk);
    wcntA = 0; rcntA = 0; dcntA = 0; firstA = -1; lastA = -1; doneAtA = -1; protoA = 0;
    for (int a = 0; a < 256; a++) cmemA[a] = 32'hFFFFFFFF;
    @(negedge clk);
    tA = 1'b1;
    modeA = m;
    @(negedge clk);
    tA = 1'b0;
    kA = ecount;
  endtask

  task automatic waitRelA(input int r);
    while (ecount + 1 - kA < r) @(negedge clk);
  endtask

  task automatic waitDoneA(input string tag);
    int n = 0;
    while (dcntA == 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(dcntA != 0), 64'd1);
    repeat (6) @(negedge clk);
  endtask

  function automatic int transposeErrA();
    int e = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (cmemA[j*16+i] !== 32'(i*16+j)) e++;
    return e;
  endfunction

  initial begin
    int err, w0, bad, n;
    rst = 1'b1;
    tA = 1'b0; modeA = 1'b0; tB = 1'b0; tC = 1'b0;
    for (int a = 0; a < 256; a++) amemA[a] = 32'(a);
    for (int a = 0; a < 32; a++) amemB[a] = 32'h1000 + 32'(a * 7);
    repeat (3) @(negedge clk);
    check("A reset outputs", 64'(anyA()), 64'd0);
    check("B reset outputs", 64'(busyB | doneB | aenB | renB | caenB | wenB | (|raddrB) | (|waddrB) | (|wdataB)), 64'd0);
    check("C reset outputs", 64'(busyC | doneC | aenC | renC | caenC | wenC | raddrC | waddrC | (|wdataC)), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 16x16 transpose, Ai[a] = a
    startA(1'b0);
    waitDoneA("A1 done seen");
    check("A1 transpose data errors", 64'(transposeErrA()), 64'd0);
    check("A1 done cycle", 64'(doneAtA + 1 - kA), 64'd259);
    check("A1 first write cycle", 64'(firstA + 1 - kA), 64'd3);
    check("A1 write count", 64'(wcntA), 64'd256);
    check("A1 writes gap-free", 64'(lastA - firstA + 1), 64'd256);
    check("A1 read count", 64'(rcntA), 64'd256);
    check("A1 done pulses", 64'(dcntA), 64'd1);
    check("A1 port protocol errors", 64'(protoA), 64'd0);
    check("A1 idle outputs", 64'(anyA()), 64'd0);

    // 16x16 copy of random data
    for (int a = 0; a < 256; a++) amemA[a] = $urandom;
    startA(1'b1);
    waitDoneA("A2 done seen");
    err = 0;
    for (int a = 0; a < 256; a++) if (cmemA[a] !== amemA[a]) err++;
    check("A2 copy data errors", 64'(err), 64'd0);
    check("A2 write count", 64'(wcntA), 64'd256);
    check("A2 done cycle", 64'(doneAtA + 1 - kA), 64'd259);

    // t (and a mode flip) while busy must be ignored
    for (int a = 0; a < 256; a++) amemA[a] = 32'(a);
    startA(1'b0);
    waitRelA(10);
    tA = 1'b1; modeA = 1'b1;
    @(negedge clk);
    tA = 1'b0;
    waitRelA(200);
    tA = 1'b1;
    @(negedge clk);
    tA = 1'b0; modeA = 1'b0;
    waitDoneA("A3 done seen");
    repeat (10) @(negedge clk);
    check("A3 single done pulse", 64'(dcntA), 64'd1);
    check("A3 write count", 64'(wcntA), 64'd256);
    check("A3 transpose data errors", 64'(transposeErrA()), 64'd0);
    check("A3 busy low after done", 64'(busyA), 64'd0);
    startA(1'b0);
    waitDoneA("A3b done seen");
    check("A3b restart data errors", 64'(transposeErrA()), 64'd0);
    check("A3b restart done cycle", 64'(doneAtA + 1 - kA), 64'd259);

    // reset mid-transfer
    startA(1'b0);
    waitRelA(50);
    rst = 1'b1;
    @(negedge clk);
    check("A4 outputs after reset", 64'(anyA()), 64'd0);
    rst = 1'b0;
    w0 = wcntA;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (anyA() !== 1'b0) bad++;
    end
    check("A4 outputs stay zero", 64'(bad), 64'd0);
    check("A4 no write after reset", 64'(wcntA), 64'(w0));
    startA(1'b0);
    waitDoneA("A4b done seen");
    check("A4b post-reset data errors", 64'(transposeErrA()), 64'd0);
    check("A4b post-reset write count", 64'(wcntA), 64'd256);

    // 4x8, RD_LAT=3
    @(posedge clk);
    wcntB = 0; dcntB = 0; firstB = -1; doneAtB = -1;
    for (int a = 0; a < 32; a++) cmemB[a] = 32'hFFFFFFFF;
    @(negedge clk);
    tB = 1'b1;
    @(negedge clk);
    tB = 1'b0;
    kB = ecount;
    n = 0;
    while (dcntB == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    err = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        if (cmemB[j*4+i] !== amemB[i*8+j]) err++;
    check("B transpose data errors", 64'(err), 64'd0);
    check("B first write cycle", 64'(firstB + 1 - kB), 64'd5);
    check("B done cycle", 64'(doneAtB + 1 - kB), 64'd37);
    check("B write count", 64'(wcntB), 64'd32);

    // 1x1
    @(posedge clk);
    rcntC = 0; wcntC = 0; dcntC = 0; doneAtC = -1;
    lastRaC = 1'b1; lastWaC = 1'b1; lastWdC = '0;
    @(negedge clk);
    tC = 1'b1;
    @(negedge clk);
    tC = 1'b0;
    kC = ecount;
    n = 0;
    while (dcntC == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("C read count", 64'(rcntC), 64'd1);
    check("C read address", 64'(lastRaC), 64'd0);
    check("C write count", 64'(wcntC), 64'd1);
    check("C write address", 64'(lastWaC), 64'd0);
    check("C write data", 64'(lastWdC), 64'hDEADBEEF);
    check("C done cycle", 64'(doneAtC + 1 - kC), 64'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
